// File: rtl/signed_booth_multiplier_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package   : signed_mult_pkg
// Purpose   : Shared types for the sequential radix-2 Booth multiplier:
//             FSM state encoding, Booth step operation and its decoder.
// Revision  : 1.0  initial release
// ============================================================================
package signed_mult_pkg;

  localparam int STATE_W = 2;

  // Encodings are visible on the STATE debug tap and must stay fixed.
  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_op_t;

  // Radix-2 Booth recoding of the pair {Q[0], Q(-1)}.
  function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
    booth_op_t op;
    case ({q0, qm1})
      2'b01:   op = ADD;
      2'b10:   op = SUB;
      default: op = NOP;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/signed_booth_multiplier_seq_booth_step.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module    : booth_step
// Purpose   : One combinational radix-2 Booth iteration: conditional add or
//             subtract of the sign-extended multiplicand into the accumulator,
//             then a 1-bit arithmetic right shift of {A, Q, Q(-1)}.
// Ports     : i_a    [WIDTH:0]   accumulator in (one guard bit)
//             i_q    [WIDTH-1:0] multiplier / low-product in
//             i_qm1              Booth lookahead bit in
//             i_m    [WIDTH-1:0] multiplicand
//             o_a, o_q, o_qm1    shifted results
// Revision  : 1.0  initial release
// ============================================================================
module booth_step
  import signed_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_qm1,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q,
  output logic             o_qm1
);

  booth_op_t        w_op;
  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_sum;

  always_comb begin
    w_m_ext = {i_m[WIDTH-1], i_m};
    w_op    = booth_decode(i_q[0], i_qm1);
    case (w_op)
      ADD:     w_sum = i_a + w_m_ext;
      SUB:     w_sum = i_a - w_m_ext;
      default: w_sum = i_a;
    endcase
    // Sign bit of the guarded accumulator is replicated; Q[0] becomes Q(-1).
    {o_a, o_q, o_qm1} = {w_sum[WIDTH], w_sum, i_q};
  end

endmodule
`default_nettype wire

// File: rtl/signed_booth_multiplier_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module    : signed_booth_multiplier_seq
// Purpose   : Sequential radix-2 Booth signed multiplier, WIDTH x WIDTH ->
//             2*WIDTH, one Booth step per clock, START/BUSY/DONE handshake.
// Ports     : clk, reset_n (async, active low)
//             plicand, plier   operands (two's complement)
//             load_m, load_q   operand load strobes (honoured outside RUN)
//             start            begin multiply (honoured outside RUN)
//             busy, done       handshake status
//             product          registered result, held until next completion
//             m, q, a, state, q_shift_out   debug taps
// Config    : SIGNED_MULT_EARLY_EXIT_EN  - finish early once the remaining
//             multiplier bits need no further add/sub.
// Revision  : 1.0  initial release
// ============================================================================
module signed_booth_multiplier_seq
  import signed_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     plicand,
  input  logic [WIDTH-1:0]     plier,
  input  logic                 load_m,
  input  logic                 load_q,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     m,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH:0]       a,
  output logic [STATE_W-1:0]   state,
  output logic                 q_shift_out
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH:0]     r_a;
  logic               r_qm1;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_m_next;
  logic [WIDTH-1:0]   w_q_next;
  logic               w_finish;
  logic [WIDTH:0]     w_a_step;
  logic [WIDTH-1:0]   w_q_step;
  logic               w_qm1_step;
  logic [WIDTH:0]     w_a_fin;
  logic [WIDTH-1:0]   w_q_fin;
  logic               w_qm1_fin;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .i_a   (r_a),
    .i_q   (r_q),
    .i_qm1 (r_qm1),
    .i_m   (r_m),
    .o_a   (w_a_step),
    .o_q   (w_q_step),
    .o_qm1 (w_qm1_step)
  );

`ifdef SIGNED_MULT_EARLY_EXIT_EN
  // The unprocessed multiplier bits sit in Q[cnt-1:0]. If they are all equal,
  // every step after the current one recodes to NOP, so the current step
  // (which may still add/sub on the Q[0]/Q(-1) boundary) is applied and the
  // remaining cnt-1 shifts are done at once. Q=0 or Q=-1 finish in one cycle.
  logic [WIDTH-1:0]   w_mask;
  logic [WIDTH-1:0]   w_q_low;
  logic               w_uniform;
  logic [2*WIDTH+1:0] w_tail;

  always_comb begin
    // cnt==WIDTH wraps the shifted one to zero, giving an all-ones mask.
    w_mask    = (WIDTH'(1) << r_cnt) - WIDTH'(1);
    w_q_low   = r_q & w_mask;
    w_uniform = (w_q_low == '0) || (w_q_low == w_mask);
    w_tail    = $signed({w_a_step, w_q_step, w_qm1_step}) >>> (r_cnt - CNT_ONE);
  end

  assign w_finish                      = (r_cnt == CNT_ONE) || w_uniform;
  assign {w_a_fin, w_q_fin, w_qm1_fin} = w_tail;
`else
  assign w_finish  = (r_cnt == CNT_ONE);
  assign w_a_fin   = w_a_step;
  assign w_q_fin   = w_q_step;
  assign w_qm1_fin = w_qm1_step;
`endif

  // Operand loads are accepted only outside RUN; a load on the START edge
  // lands in M/Q before the first Booth step reads them.
  always_comb begin
    w_m_next = r_m;
    w_q_next = r_q;
    if (r_state != RUN) begin
      if (load_m) w_m_next = plicand;
      if (load_q) w_q_next = plier;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_next = RUN;
      RUN:        if (w_finish) w_state_next = DONE;
      default:    w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m       <= '0;
      r_q       <= '0;
      r_a       <= '0;
      r_qm1     <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_m <= w_m_next;
          r_q <= w_q_next;
          if (start) begin
            r_a   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= CNT_INIT;
          end
        end
        RUN: begin
          r_a   <= w_a_fin;
          r_q   <= w_q_fin;
          r_qm1 <= w_qm1_fin;
          r_cnt <= w_finish ? '0 : (r_cnt - CNT_ONE);
          // The guard bit is dropped: the true product always fits 2*WIDTH.
          if (w_finish) r_product <= {w_a_fin[WIDTH-1:0], w_q_fin};
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign product     = r_product;
  assign m           = r_m;
  assign q           = r_q;
  assign a           = r_a;
  assign state       = r_state;
  assign q_shift_out = r_qm1;

endmodule
`default_nettype wire

// File: tb/tb_signed_booth_multiplier_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module    : tb_signed_booth_multiplier_seq
// Purpose   : Self-checking bench for signed_booth_multiplier_seq. Four
//             instances (WIDTH 2, 4, 8, 16) share stimulus; each takes the low
//             WIDTH bits of the 16-bit operands.
// Revision  : 1.0  initial release
// ============================================================================
module tb_signed_booth_multiplier_seq;

  localparam int N_DUT = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [15:0]      plicand = '0;
  logic [15:0]      plier = '0;
  logic             load_m = 1'b0;
  logic             load_q = 1'b0;
  logic             start = 1'b0;

  logic [N_DUT-1:0] busy_v;
  logic [N_DUT-1:0] done_v;
  logic [N_DUT-1:0] qso_v;
  logic [31:0]      prod_w [N_DUT];
  logic [15:0]      m_w    [N_DUT];
  logic [15:0]      q_w    [N_DUT];
  logic [16:0]      a_w    [N_DUT];
  logic [1:0]       st_w   [N_DUT];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
    localparam int W = 2 << gi;
    logic [2*W-1:0] product;
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [W:0]     a;
    logic [1:0]     state;

    signed_booth_multiplier_seq #(.WIDTH(W)) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .plicand     (plicand[W-1:0]),
      .plier       (plier[W-1:0]),
      .load_m      (load_m),
      .load_q      (load_q),
      .start       (start),
      .busy        (busy_v[gi]),
      .done        (done_v[gi]),
      .product     (product),
      .m           (m),
      .q           (q),
      .a           (a),
      .state       (state),
      .q_shift_out (qso_v[gi])
    );

    assign prod_w[gi] = 32'(product);
    assign m_w[gi]    = 16'(m);
    assign q_w[gi]    = 16'(q);
    assign a_w[gi]    = 17'(a);
    assign st_w[gi]   = state;
  end

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt [N_DUT];

  typedef struct {
    int          idx;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        same_edge;
    logic [31:0] e4;
    logic [31:0] e8;
  } vec_t;
  vec_t vecs [6];

  // Reference: sign-extend the low w bits of each operand and multiply.
  function automatic logic [31:0] model(input int w, input logic [15:0] x, input logic [15:0] y);
    logic signed [15:0] sx;
    logic signed [15:0] sy;
    longint             p;
    logic [31:0]        mask;
    sx = x << (16 - w);
    sx = sx >>> (16 - w);
    sy = y << (16 - w);
    sy = sy >>> (16 - w);
    p = longint'(sx) * longint'(sy);
    mask = (w == 16) ? 32'hFFFF_FFFF : ((32'd1 << (2 * w)) - 32'd1);
    return 32'(p) & mask;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input logic [3:0] mask, input string tag);
    int cyc = 0;
    while (((done_v & mask) != mask) && (cyc < 64)) begin
      cyc++;
      @(negedge clk);
    end
    check($sformatf("%s done reached", tag), 32'(done_v & mask), 32'(mask));
  endtask

  // Load operands, start, push expectations, wait for all four to finish,
  // then drain the scoreboard and check BUSY duration.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic se,
                        input logic [31:0] e4, input logic [31:0] e8, input string tag);
    int cyc = 0;
    @(negedge clk);
    plicand = x; plier = y; load_m = 1'b1; load_q = 1'b1; start = se;
    if (!se) begin
      @(negedge clk);
      load_m = 1'b0; load_q = 1'b0; start = 1'b1;
    end
    sb_q.push_back('{0, model(2, x, y)});
    sb_q.push_back('{1, e4});
    sb_q.push_back('{2, e8});
    sb_q.push_back('{3, model(16, x, y)});
    @(negedge clk);
    load_m = 1'b0; load_q = 1'b0; start = 1'b0;
    check($sformatf("%s done dropped on start", tag), 32'(done_v), 32'h0);
    for (int i = 0; i < N_DUT; i++) busy_cnt[i] = 0;
    while ((done_v != 4'hF) && (cyc < 64)) begin
      for (int i = 0; i < N_DUT; i++) if (busy_v[i]) busy_cnt[i]++;
      cyc++;
      @(negedge clk);
    end
    check($sformatf("%s all done", tag), 32'(done_v), 32'hF);
    while (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      check($sformatf("%s W%0d product", tag, 2 << e.idx), prod_w[e.idx], e.exp);
    end
`ifndef SIGNED_MULT_EARLY_EXIT_EN
    for (int i = 0; i < N_DUT; i++)
      check($sformatf("%s W%0d busy cycles", tag, 2 << i), 32'(busy_cnt[i]), 32'(2 << i));
`endif
  endtask

  initial begin
    vecs[0] = '{16'h0007, 16'hFFF8, 1'b0, 32'h0000_00C8, 32'h0000_FFC8};
    vecs[1] = '{16'hFFF8, 16'hFFF8, 1'b0, 32'h0000_0040, 32'h0000_0040};
    vecs[2] = '{16'hFF80, 16'hFF80, 1'b0, 32'h0000_0000, 32'h0000_4000};
    vecs[3] = '{16'h0003, 16'hFFFB, 1'b1, 32'h0000_00F1, 32'h0000_FFF1};
    vecs[4] = '{16'h0005, 16'h0002, 1'b0, 32'h0000_000A, 32'h0000_000A};
    vecs[5] = '{16'h0009, 16'h0009, 1'b1, 32'h0000_0031, 32'h0000_0051};

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("reset W%0d state", 2 << i), 32'(st_w[i]), 32'h0);
      check($sformatf("reset W%0d busy/done", 2 << i), {30'b0, busy_v[i], done_v[i]}, 32'h0);
      check($sformatf("reset W%0d product", 2 << i), prod_w[i], 32'h0);
      check($sformatf("reset W%0d m/q", 2 << i), {m_w[i], q_w[i]}, 32'h0);
      check($sformatf("reset W%0d a/qso", 2 << i), {14'b0, a_w[i], qso_v[i]}, 32'h0);
    end
    reset_n = 1'b1;

    // Table-driven vectors
    for (int k = 0; k < 6; k++)
      run_op(vecs[k].x, vecs[k].y, vecs[k].same_edge, vecs[k].e4, vecs[k].e8,
             $sformatf("vec%0d", k));

    // DONE persists; a load in DONE updates M but not PRODUCT
    @(negedge clk);
    plicand = 16'h0003; load_m = 1'b1;
    @(negedge clk);
    load_m = 1'b0;
    check("done load keeps done", 32'(done_v), 32'hF);
    check("done load keeps product", prod_w[1], vecs[5].e4);
    check("done load updates m", 32'(m_w[1]), 32'h3);
    repeat (3) @(negedge clk);
    check("done persists", 32'(done_v), 32'hF);

    // START and loads during RUN are ignored (W4/W8/W16)
    @(negedge clk);
    plicand = 16'h0005; plier = 16'hFFFD; load_m = 1'b1; load_q = 1'b1; start = 1'b1;
    @(negedge clk);
    load_m = 1'b0; load_q = 1'b0; start = 1'b0;
    @(negedge clk);
    plicand = 16'h0001; plier = 16'h0000; load_m = 1'b1; load_q = 1'b1; start = 1'b1;
    @(negedge clk);
    load_m = 1'b0; load_q = 1'b0; start = 1'b0;
    wait_done(4'hE, "ignore");
    check("ignore W4 product", prod_w[1], 32'h0000_00F1);
    check("ignore W8 product", prod_w[2], 32'h0000_FFF1);
    check("ignore W16 product", prod_w[3], model(16, 16'h0005, 16'hFFFD));
    check("ignore W4 m kept", 32'(m_w[1]), 32'h5);

    // Asynchronous reset in RUN cycle 2
    @(negedge clk);
    plicand = 16'h0007; plier = 16'hFFF8; load_m = 1'b1; load_q = 1'b1; start = 1'b1;
    @(negedge clk);
    load_m = 1'b0; load_q = 1'b0; start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    for (int i = 1; i < N_DUT; i++) begin
      check($sformatf("midrun reset W%0d state", 2 << i), 32'(st_w[i]), 32'h0);
      check($sformatf("midrun reset W%0d busy/done", 2 << i), {30'b0, busy_v[i], done_v[i]}, 32'h0);
      check($sformatf("midrun reset W%0d product", 2 << i), prod_w[i], 32'h0);
      check($sformatf("midrun reset W%0d a/q", 2 << i), {15'b0, a_w[i]} | {16'b0, q_w[i]}, 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_op(16'h0007, 16'hFFF8, 1'b0, 32'h0000_00C8, 32'h0000_FFC8, "after reset");

`ifdef SIGNED_MULT_EARLY_EXIT_EN
    run_op(16'h0025, 16'h0000, 1'b0, 32'h0, 32'h0, "early q0");
    check("early q0 W8 busy cycles", 32'(busy_cnt[2]), 32'd1);
    run_op(16'h0025, 16'h0002, 1'b0, model(4, 16'h0025, 16'h0002), 32'h0000_004A, "early q2");
    check("early q2 W8 busy cycles", 32'(busy_cnt[2]), 32'd3);
`endif

    // Random signed pairs
    for (int k = 0; k < 12; k++) begin
      logic [15:0] rx;
      logic [15:0] ry;
      rx = 16'($urandom);
      ry = 16'($urandom);
      run_op(rx, ry, 1'($urandom_range(0, 1)), model(4, rx, ry), model(8, rx, ry),
             $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
